// File: rtl/spi_master_mux.sv
`default_nettype none
// spi_master_mux: single-clock multi-slave SPI master with per-slave CPOL/CPHA, multi-word frames and an RX FIFO.
// Define SPI_LOOPBACK_EN to sample the master's own mosi instead of miso (board self-test).
module spi_master_mux #(
   parameter int                    N_SLAVES = 4,
   parameter int                    DATA_W   = 8,
   parameter int                    CLK_DIV  = 4,
   parameter logic [N_SLAVES-1:0]   CPOL_VEC = '0,
   parameter logic [N_SLAVES-1:0]   CPHA_VEC = '0,
   parameter int                    RX_DEPTH = 16,
   parameter int                    CS_IDLE  = 2,
   localparam int                   SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
   localparam int                   LVL_W    = $clog2(RX_DEPTH) + 1
) (
   input  logic                sys_clk,
   input  logic                n_rst,
   input  logic [DATA_W-1:0]   tx_data,
   input  logic [SEL_W-1:0]    tx_sel,
   input  logic                tx_last,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [DATA_W-1:0]   rx_data,
   output logic                rx_valid,
   input  logic                rx_rdreq,
   output logic [LVL_W-1:0]    rx_level,
   output logic                rx_ovf,
   output logic                busy,
   output logic [N_SLAVES-1:0] n_cs_bus,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso
);
   localparam int SEL_N   = 2**SEL_W;
   localparam int AW      = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int EDGE_W  = $clog2(2 * DATA_W);
   // Out-of-range selects read zero-extended mode bits, i.e. mode 0.
   localparam logic [SEL_N-1:0] CPOL_X = SEL_N'(CPOL_VEC);
   localparam logic [SEL_N-1:0] CPHA_X = SEL_N'(CPHA_VEC);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_SETUP, S_SHIFT, S_NEXT, S_HOLD, S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                last_q, last_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic                push_q, push_d, ovf_q, ovf_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic [N_SLAVES-1:0] n_cs_q, n_cs_d;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [DATA_W-1:0]   mem_q [RX_DEPTH];
   logic                w_cnt_end, w_cpha, w_sample, w_pop, w_full, w_wr, w_cs_act;

`ifdef SPI_LOOPBACK_EN
   logic w_unused_miso;
   assign w_unused_miso = miso;
   assign w_sample      = mosi_q;
`else
   assign w_sample      = miso;
`endif

   assign w_cnt_end = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign w_cpha    = CPHA_X[sel_q];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      edge_d   = edge_q;
      sel_d    = sel_q;
      last_d   = last_q;
      tx_sh_d  = tx_sh_q;
      rx_sh_d  = rx_sh_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      push_d   = 1'b0;
      tx_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               sel_d   = tx_sel;
               last_d  = tx_last;
               tx_sh_d = tx_data;
               sclk_d  = CPOL_X[tx_sel];
               if (!CPHA_X[tx_sel]) mosi_d = tx_data[DATA_W-1];
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            cnt_d   = '0;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            if (w_cnt_end) begin
               cnt_d   = '0;
               edge_d  = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            if (w_cnt_end) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               edge_d = edge_q + EDGE_W'(1);
               // Even edge index = leading edge, odd = trailing edge.
               if (edge_q[0] == w_cpha) begin
                  rx_sh_d = {rx_sh_q[DATA_W-2:0], w_sample};
               end else if (w_cpha) begin
                  mosi_d  = tx_sh_q[DATA_W-1];
                  tx_sh_d = tx_sh_q << 1;
               end else begin
                  mosi_d  = tx_sh_q[DATA_W-2];
                  tx_sh_d = tx_sh_q << 1;
               end
               if (edge_q == EDGE_W'(2 * DATA_W - 1)) begin
                  push_d  = 1'b1;
                  state_d = last_q ? S_HOLD : S_NEXT;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NEXT: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               last_d  = tx_last;
               tx_sh_d = tx_data;
               if (!w_cpha) mosi_d = tx_data[DATA_W-1];
               cnt_d   = '0;
               edge_d  = '0;
               state_d = S_SHIFT;
            end
         end
         S_HOLD: begin
            if (w_cnt_end) begin
               cnt_d   = '0;
               mosi_d  = 1'b0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(CS_IDLE - 1)) state_d = S_IDLE;
            else                              cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      w_cs_act = (state_d == S_SETUP) || (state_d == S_SHIFT) ||
                 (state_d == S_NEXT)  || (state_d == S_HOLD);
      n_cs_d = '1;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (w_cs_act && (sel_d == SEL_W'(i))) n_cs_d[i] = 1'b0;
      end
   end

   // A push into a full FIFO survives only if a pop frees the slot in the same cycle.
   assign w_pop   = rx_rdreq && (level_q != '0);
   assign w_full  = (level_q == LVL_W'(RX_DEPTH));
   assign w_wr    = push_q && (!w_full || w_pop);
   assign ovf_d   = push_q && w_full && !w_pop;
   assign level_d = level_q + LVL_W'(w_wr) - LVL_W'(w_pop);

   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         edge_q   <= '0;
         sel_q    <= '0;
         last_q   <= 1'b0;
         sclk_q   <= CPOL_VEC[0];
         mosi_q   <= 1'b0;
         push_q   <= 1'b0;
         ovf_q    <= 1'b0;
         tx_sh_q  <= '0;
         rx_sh_q  <= '0;
         n_cs_q   <= '1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         edge_q   <= edge_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         push_q   <= push_d;
         ovf_q    <= ovf_d;
         tx_sh_q  <= tx_sh_d;
         rx_sh_q  <= rx_sh_d;
         n_cs_q   <= n_cs_d;
         level_q  <= level_d;
         if (w_wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= rx_sh_q;
   end

   assign rx_data  = mem_q[rd_ptr_q];
   assign rx_valid = (level_q != '0);
   assign rx_level = level_q;
   assign rx_ovf   = ovf_q;
   assign busy     = (state_q != S_IDLE);
   assign n_cs_bus = n_cs_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
endmodule
`default_nettype wire
